pc_sequencer: RTL and testbench

- Program-counter sequencer for the picoMIPS control path.
- Owns the PC and decides each cycle whether it advances, branches or holds.
- Debounces the handshake switch (SW8) so the CPU can block on "wait for button pressed/released" instructions before sampling switchesIn.
- Outputs a stall that the control path uses to suppress writeReg while the current instruction is holding.

---
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer.sv | 107 ++++++++++
 tb/tb_pc_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Decode/handshake bundle between the picoMIPS control path and pc_sequencer.
interface pc_sequencer_if #(
    parameter int P_SIZE = 5
);
    logic              btnIn;
    logic              waitHigh;
    logic              waitLow;
    logic              branch;
    logic [P_SIZE-1:0] branchTarget;
    logic [P_SIZE-1:0] pc;
    logic              stall;
    logic              btnLevel;
    logic              waiting;

    modport master (
        output btnIn, waitHigh, waitLow, branch, branchTarget,
        input  pc, stall, btnLevel, waiting
    );

    modport slave (
        input  btnIn, waitHigh, waitLow, branch, branchTarget,
        output pc, stall, btnLevel, waiting
    );
endinterface

// File: rtl/pc_sequencer.sv
// picoMIPS program-counter sequencer: PC advance/branch/hold, debounced SW8 handshake waits.
// Optional macro SINGLE_STEP_EN adds a debounced stepBtn that gates every PC update.
module pc_sequencer #(
    parameter int P_SIZE          = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic          clk,
    input  logic          nRst,
`ifdef SINGLE_STEP_EN
    input  logic          stepBtn,
`endif
    pc_sequencer_if.slave bus
);
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [0:0]       ST_RUN   = 1'b0;
    localparam logic [0:0]       ST_WAIT  = 1'b1;

    logic [1:0]        btn_sync_q, btn_sync_d;
    logic [CNT_W-1:0]  btn_cnt_q, btn_cnt_d;
    logic              btn_level_q, btn_level_d;
    logic [0:0]        state_q, state_d;
    logic [P_SIZE-1:0] pc_q, pc_d;
    logic              wait_req, wait_met, wait_stall, stall;

    // Debounce: level follows the synchronized input only after it differs for DEBOUNCE_CYCLES edges
    always_comb begin
        btn_sync_d  = {btn_sync_q[0], bus.btnIn};
        btn_cnt_d   = '0;
        btn_level_d = btn_level_q;
        if (btn_sync_q[1] != btn_level_q) begin
            if (btn_cnt_q == CNT_LAST) btn_level_d = btn_sync_q[1];
            else                       btn_cnt_d   = btn_cnt_q + CNT_W'(1);
        end
    end

    // Both wait flags together is an illegal decode and retires as a plain instruction
    always_comb begin
        wait_req   = bus.waitHigh ^ bus.waitLow;
        wait_met   = (bus.waitHigh & btn_level_q) | (bus.waitLow & ~btn_level_q);
        wait_stall = wait_req & ~wait_met;
    end

`ifdef SINGLE_STEP_EN
    logic [1:0]       step_sync_q, step_sync_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             step_level_q, step_level_d;
    logic             step_prev_q;
    logic             step_pulse;

    always_comb begin
        step_sync_d  = {step_sync_q[0], stepBtn};
        step_cnt_d   = '0;
        step_level_d = step_level_q;
        if (step_sync_q[1] != step_level_q) begin
            if (step_cnt_q == CNT_LAST) step_level_d = step_sync_q[1];
            else                        step_cnt_d   = step_cnt_q + CNT_W'(1);
        end
        step_pulse = step_level_q & ~step_prev_q;
        stall      = wait_stall | ~step_pulse;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            step_sync_q  <= '0;
            step_cnt_q   <= '0;
            step_level_q <= 1'b0;
            step_prev_q  <= 1'b0;
        end else begin
            step_sync_q  <= step_sync_d;
            step_cnt_q   <= step_cnt_d;
            step_level_q <= step_level_d;
            step_prev_q  <= step_level_q;
        end
    end
`else
    always_comb stall = wait_stall;
`endif

    // WAIT tracks the handshake wait only; a stall from single-step gating is not a wait
    always_comb begin
        state_d = wait_stall ? ST_WAIT : ST_RUN;
        pc_d    = pc_q;
        if (!stall) pc_d = bus.branch ? bus.branchTarget : pc_q + P_SIZE'(1);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            btn_sync_q  <= '0;
            btn_cnt_q   <= '0;
            btn_level_q <= 1'b0;
            state_q     <= ST_RUN;
            pc_q        <= '0;
        end else begin
            btn_sync_q  <= btn_sync_d;
            btn_cnt_q   <= btn_cnt_d;
            btn_level_q <= btn_level_d;
            state_q     <= state_d;
            pc_q        <= pc_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.stall    = stall;
    assign bus.btnLevel = btn_level_q;
    assign bus.waiting  = (state_q == ST_WAIT);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with DEBOUNCE_CYCLES=4, P_SIZE=5 (default build).
module tb_pc_sequencer;
    logic clk;
    logic nRst;
    int   checks;
    int   errors;

    pc_sequencer_if #(.P_SIZE(5)) bus ();

`ifdef SINGLE_STEP_EN
    logic stepBtn;
    pc_sequencer #(.P_SIZE(5), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .nRst(nRst), .stepBtn(stepBtn), .bus(bus.slave));
`else
    pc_sequencer #(.P_SIZE(5), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .nRst(nRst), .bus(bus.slave));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_decode();
        bus.waitHigh     = 1'b0;
        bus.waitLow      = 1'b0;
        bus.branch       = 1'b0;
        bus.branchTarget = 5'h00;
    endtask

    task automatic goto_pc(input int v);
        nRst = 1'b0;
        #2;
        nRst = 1'b1;
        repeat (v) tick();
    endtask

    task automatic test_reset();
        nRst = 1'b1;
        #1 nRst = 1'b0;
        tick();
        checks++; if (bus.pc !== 5'h00) begin errors++; $display("FAIL reset_pc got=%0h exp=0", bus.pc); end
        checks++; if (bus.btnLevel !== 1'b0) begin errors++; $display("FAIL reset_btnLevel got=%0b exp=0", bus.btnLevel); end
        checks++; if (bus.waiting !== 1'b0) begin errors++; $display("FAIL reset_waiting got=%0b exp=0", bus.waiting); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
        nRst = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            checks++; if (bus.pc !== 5'(i)) begin errors++; $display("FAIL advance_pc step=%0d got=%0h exp=%0h", i, bus.pc, i); end
            checks++; if (bus.stall !== 1'b0 || bus.waiting !== 1'b0) begin
                errors++; $display("FAIL advance_flags step=%0d stall=%0b waiting=%0b exp=0/0", i, bus.stall, bus.waiting); end
        end
        #2 nRst = 1'b0;
        #1;
        checks++; if (bus.pc !== 5'h00) begin errors++; $display("FAIL async_reset_pc got=%0h exp=0", bus.pc); end
        nRst = 1'b1;
        tick();
        checks++; if (bus.pc !== 5'h01) begin errors++; $display("FAIL post_reset_pc got=%0h exp=1", bus.pc); end
    endtask

    task automatic test_debounce();
        bus.btnIn = 1'b1;
        repeat (3) tick();
        bus.btnIn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (bus.btnLevel !== 1'b0) begin errors++; $display("FAIL glitch_level cyc=%0d got=%0b exp=0", i, bus.btnLevel); end
        end
        bus.btnIn = 1'b1;
        repeat (5) tick();
        checks++; if (bus.btnLevel !== 1'b0) begin errors++; $display("FAIL rise_edge5 got=%0b exp=0", bus.btnLevel); end
        tick();
        checks++; if (bus.btnLevel !== 1'b1) begin errors++; $display("FAIL rise_edge6 got=%0b exp=1", bus.btnLevel); end
        bus.btnIn = 1'b0;
        repeat (5) tick();
        checks++; if (bus.btnLevel !== 1'b1) begin errors++; $display("FAIL fall_edge5 got=%0b exp=1", bus.btnLevel); end
        tick();
        checks++; if (bus.btnLevel !== 1'b0) begin errors++; $display("FAIL fall_edge6 got=%0b exp=0", bus.btnLevel); end
    endtask

    task automatic test_wait_high();
        goto_pc(5);
        bus.waitHigh = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wh_stall got=%0b exp=1", bus.stall); end
        tick();
        checks++; if (bus.pc !== 5'h05) begin errors++; $display("FAIL wh_hold_pc got=%0h exp=5", bus.pc); end
        checks++; if (bus.waiting !== 1'b1) begin errors++; $display("FAIL wh_waiting got=%0b exp=1", bus.waiting); end
        bus.btnIn = 1'b1;
        repeat (5) tick();
        checks++; if (bus.pc !== 5'h05 || bus.stall !== 1'b1) begin
            errors++; $display("FAIL wh_still_held pc=%0h stall=%0b exp=5/1", bus.pc, bus.stall); end
        tick();
        checks++; if (bus.btnLevel !== 1'b1 || bus.stall !== 1'b0 || bus.pc !== 5'h05) begin
            errors++; $display("FAIL wh_met lvl=%0b stall=%0b pc=%0h exp=1/0/5", bus.btnLevel, bus.stall, bus.pc); end
        tick();
        checks++; if (bus.pc !== 5'h06) begin errors++; $display("FAIL wh_retire_pc got=%0h exp=6", bus.pc); end
        checks++; if (bus.waiting !== 1'b0) begin errors++; $display("FAIL wh_retire_waiting got=%0b exp=0", bus.waiting); end
        bus.waitHigh = 1'b0;
    endtask

    task automatic test_wait_branch();
        bus.waitLow      = 1'b1;
        bus.branch       = 1'b1;
        bus.branchTarget = 5'h12;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL wb_stall got=%0b exp=1", bus.stall); end
        tick();
        checks++; if (bus.pc !== 5'h06) begin errors++; $display("FAIL wb_hold_pc got=%0h exp=6", bus.pc); end
        bus.btnIn = 1'b0;
        repeat (6) tick();
        checks++; if (bus.pc !== 5'h06 || bus.btnLevel !== 1'b0 || bus.stall !== 1'b0) begin
            errors++; $display("FAIL wb_met pc=%0h lvl=%0b stall=%0b exp=6/0/0", bus.pc, bus.btnLevel, bus.stall); end
        tick();
        checks++; if (bus.pc !== 5'h12) begin errors++; $display("FAIL wb_branch_pc got=%0h exp=12", bus.pc); end
        checks++; if (bus.waiting !== 1'b0) begin errors++; $display("FAIL wb_waiting got=%0b exp=0", bus.waiting); end
        clear_decode();
    endtask

    task automatic test_back_to_back();
        bus.branch       = 1'b1;
        bus.branchTarget = 5'h0A;
        tick();
        checks++; if (bus.pc !== 5'h0A) begin errors++; $display("FAIL b2b_first got=%0h exp=a", bus.pc); end
        tick();
        checks++; if (bus.pc !== 5'h0A) begin errors++; $display("FAIL b2b_self got=%0h exp=a", bus.pc); end
        bus.branchTarget = 5'h1E;
        tick();
        checks++; if (bus.pc !== 5'h1E) begin errors++; $display("FAIL b2b_second got=%0h exp=1e", bus.pc); end
        bus.branch = 1'b0;
        tick();
        checks++; if (bus.pc !== 5'h1F) begin errors++; $display("FAIL b2b_advance got=%0h exp=1f", bus.pc); end
        tick();
        checks++; if (bus.pc !== 5'h00) begin errors++; $display("FAIL b2b_wrap got=%0h exp=0", bus.pc); end
        clear_decode();
    endtask

    task automatic test_wrap_illegal();
        goto_pc(31);
        checks++; if (bus.pc !== 5'h1F) begin errors++; $display("FAIL wrap_pre got=%0h exp=1f", bus.pc); end
        tick();
        checks++; if (bus.pc !== 5'h00) begin errors++; $display("FAIL wrap_pc got=%0h exp=0", bus.pc); end
        goto_pc(3);
        bus.waitHigh = 1'b1;
        bus.waitLow  = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL illegal_stall got=%0b exp=0", bus.stall); end
        tick();
        checks++; if (bus.pc !== 5'h04 || bus.waiting !== 1'b0) begin
            errors++; $display("FAIL illegal_retire pc=%0h waiting=%0b exp=4/0", bus.pc, bus.waiting); end
        clear_decode();
    endtask

    task automatic test_reset_mid_wait();
        goto_pc(7);
        bus.waitHigh = 1'b1;
        tick();
        checks++; if (bus.pc !== 5'h07 || bus.waiting !== 1'b1) begin
            errors++; $display("FAIL rmw_wait pc=%0h waiting=%0b exp=7/1", bus.pc, bus.waiting); end
        #2 nRst = 1'b0;
        #1;
        checks++; if (bus.pc !== 5'h00 || bus.waiting !== 1'b0) begin
            errors++; $display("FAIL rmw_reset pc=%0h waiting=%0b exp=0/0", bus.pc, bus.waiting); end
        bus.waitHigh = 1'b0;
        nRst = 1'b1;
        tick();
        checks++; if (bus.pc !== 5'h01 || bus.waiting !== 1'b0) begin
            errors++; $display("FAIL rmw_resume pc=%0h waiting=%0b exp=1/0", bus.pc, bus.waiting); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.btnIn = 1'b0;
        clear_decode();
`ifdef SINGLE_STEP_EN
        stepBtn = 1'b0;
`endif
        test_reset();
        test_debounce();
        test_wait_high();
        test_wait_branch();
        test_back_to_back();
        test_wrap_illegal();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
